// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier: latches a signed operand pair, retires one Booth digit
// per clock into a double-width accumulator, then holds the product until it is accepted.
module booth_seq_mult_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     MR,
  input  logic [WIDTH-1:0]     MD,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 busy
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned Digits = WIDTH / 2;
  localparam int unsigned IdxW   = (Digits > 1) ? $clog2(Digits) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [PW-1:0]   One     = PW'(1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Digits - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH:0]   mr_ext;
  logic [WIDTH:0]   digit_win;
  logic [2:0]       triple;
  logic [PW-1:0]    md_ext;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    pp_shifted;
  logic [PW-1:0]    acc_sum;
  logic             last_digit;

  // Appending a zero below the LSB supplies b[-1] for digit 0.
  always_comb begin
    mr_ext    = {mr_q, 1'b0};
    digit_win = mr_ext >> {idx_q, 1'b0};
    triple    = digit_win[2:0];
    md_ext    = {{WIDTH{md_q[WIDTH-1]}}, md_q};
    case (triple)
      3'b001, 3'b010: pp = md_ext;
      3'b011:         pp = md_ext << 1;
      3'b100:         pp = ~(md_ext << 1) + One;
      3'b101, 3'b110: pp = ~md_ext + One;
      default:        pp = '0;
    endcase
    pp_shifted = pp << {idx_q, 1'b0};
    acc_sum    = acc_q + pp_shifted;
    last_digit = (idx_q == LastIdx);
  end

  always_comb begin
    state_d   = state_q;
    mr_d      = mr_q;
    md_d      = md_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start_valid) begin
          mr_d    = MR;
          md_d    = MD;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_sum;
        if (last_digit) begin
          product_d = acc_sum;
          state_d   = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mr_q      <= '0;
      md_q      <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mr_q      <= mr_d;
      md_q      <= md_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      product_q <= product_d;
    end
  end

  // Handshake outputs come from the state register only.
  assign start_ready = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign Product     = product_q;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed bench for booth_seq_mult_ctrl: vector table at WIDTH=8, handshake corner sequences,
// and an exhaustive sweep on a WIDTH=4 instance.
module tb_booth_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid, out_ready;
  logic        start_ready, out_valid, busy;
  logic [7:0]  MR, MD;
  logic [15:0] Product;

  logic        sv4, or4, sr4, ov4, busy4;
  logic [3:0]  mr4, md4;
  logic [7:0]  prod4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_seq_mult_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .MR(MR), .MD(MD), .out_valid(out_valid), .out_ready(out_ready),
    .Product(Product), .busy(busy)
  );

  booth_seq_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4),
    .MR(mr4), .MD(md4), .out_valid(ov4), .out_ready(or4),
    .Product(prod4), .busy(busy4)
  );

  typedef struct {
    logic [7:0]  mr;
    logic [7:0]  md;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input int hold, input bit toggle, input string name);
    int lat;
    bit busy_ok, stable_ok;
    chk({name, " ready_before"}, {31'd0, start_ready}, 32'd1);
    MR = a;
    MD = b;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      if (!busy || start_ready) busy_ok = 1'b0;
      if (toggle) begin
        MR = 8'($urandom);
        MD = 8'($urandom);
        start_valid = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start_valid = 1'b0;
    out_ready = 1'b0;
    if (!busy || start_ready) busy_ok = 1'b0;
    chk({name, " latency"}, lat, 32'd4);
    chk({name, " product"}, {16'd0, Product}, {16'd0, exp});
    chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
        if (!out_valid || Product !== exp || start_ready || !busy) stable_ok = 1'b0;
        @(negedge clk);
      end
      chk({name, " backpressure_stable"}, {31'd0, stable_ok}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " handoff"}, {29'd0, out_valid, start_ready, busy}, 32'b010);
  endtask

  initial begin
    int n_acc, n_prod, lat;
    int acc_cyc[2];
    logic [15:0] prods[2];
    logic [7:0] exp4;

    vecs[0] = '{8'd7,    8'hFD, 16'hFFEB};
    vecs[1] = '{8'h80,   8'h80, 16'h4000};
    vecs[2] = '{8'h80,   8'h7F, 16'hC080};
    vecs[3] = '{8'd0,    8'hFF, 16'h0000};
    vecs[4] = '{8'hFF,   8'hFF, 16'h0001};
    vecs[5] = '{8'd127,  8'd127, 16'h3F01};
    vecs[6] = '{8'hFE,   8'd5,  16'hFFF6};
    vecs[7] = '{8'd100,  8'hCE, 16'hEC78};
    vecs[8] = '{8'd3,    8'd3,  16'h0009};

    rst = 1'b1;
    start_valid = 1'b0; out_ready = 1'b0; MR = '0; MD = '0;
    sv4 = 1'b0; or4 = 1'b0; mr4 = '0; md4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset state", {13'd0, start_ready, out_valid, busy, Product}, {13'd0, 3'b100, 16'h0});

    for (int v = 0; v < 9; v++)
      run8(vecs[v].mr, vecs[v].md, vecs[v].prod, 0, 1'b0, $sformatf("vec%0d", v));

    // Long backpressure plus noisy inputs during CALC.
    run8(8'd7, 8'hFD, 16'hFFEB, 10, 1'b1, "bp_toggle");

    // Back-to-back with start_valid and out_ready held high.
    n_acc = 0;
    n_prod = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n_prod < 2; cyc++) begin
      start_valid = (n_acc < 2);
      MR = (n_acc == 0) ? 8'd5 : 8'hFC;
      MD = (n_acc == 0) ? 8'd6 : 8'd9;
      if (out_valid) begin
        prods[n_prod] = Product;
        n_prod++;
      end
      if (start_ready && start_valid && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    start_valid = 1'b0;
    chk("b2b count", n_prod * 10 + n_acc, 32'd22);
    chk("b2b prod0", {16'd0, prods[0]}, 32'h001E);
    chk("b2b prod1", {16'd0, prods[1]}, 32'hFFDC);
    chk("b2b spacing", acc_cyc[1] - acc_cyc[0], 32'd6);

    // Reset while digit 2 is being retired.
    MR = 8'd7; MD = 8'hFD; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset", {13'd0, start_ready, out_valid, busy, Product}, {13'd0, 3'b100, 16'h0});
    run8(8'd3, 8'd3, 16'h0009, 0, 1'b0, "after_reset");

    // Exhaustive WIDTH=4 sweep.
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        mr4 = 4'(a);
        md4 = 4'(b);
        sv4 = 1'b1;
        @(negedge clk);
        sv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        exp4 = 8'(a * b);
        tests++;
        if (lat != 2 || prod4 !== exp4) begin
          fails++;
          $display("FAIL w4 %0d*%0d: got %0h lat %0d expected %0h lat 2", a, b, prod4, lat, exp4);
        end
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
